secded_scrubber: RTL and testbench

//  Background scrub engine for a SECDED-protected memory of 39-bit codewords (32 data + 7 check).

---
 rtl/secded_scrubber_pkg.sv | 33 +++
 rtl/secded_scrubber_if.sv | 25 ++
 rtl/secded_scrubber_ecc.sv | 38 +++
 rtl/secded_scrubber.sv | 139 +++++++++++++
 tb/tb_secded_scrubber.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/secded_scrubber_pkg.sv
// Shared types and constants for the SECDED scrub engine: codeword geometry,
// syndrome classes and scrubber FSM states.
package secded_scrubber_pkg;

    localparam int unsigned CW_W   = 39;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SYND_W = CW_W - DATA_W;

    typedef enum logic [1:0] {
        CLEAN,
        SINGLE,
        DOUBLE
    } synd_class_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        CHECK,
        WRITE,
        NEXT
    } scrub_state_e;

    // synd[MSB] is overall parity: odd weight means one flipped bit (possibly a check bit).
    function automatic synd_class_e classify_synd(input logic [SYND_W-1:0] synd);
        if (synd == '0)
            return CLEAN;
        if (synd[SYND_W-1])
            return SINGLE;
        return DOUBLE;
    endfunction

endpackage

// File: rtl/secded_scrubber_if.sv
// Memory-side request/ack port of the scrubber; master = scrubber, slave = RAM.
interface secded_scrubber_if
    import secded_scrubber_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [CW_W-1:0]   mem_wdata;
    logic              mem_ack;
    logic [CW_W-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/secded_scrubber_ecc.sv
// Combinational SECDED (error_correction) stage: cw[i] holds Hamming position i+1
// (check bits at powers of two), cw[38] is overall parity.
module secded_scrubber_ecc
    import secded_scrubber_pkg::*;
(
    input  logic [CW_W-1:0]   codeword,
    output logic [SYND_W-1:0] synd,
    output logic [CW_W-1:0]   corrected
);

    localparam int unsigned HAM_N = CW_W - 1;
    localparam int unsigned POS_W = SYND_W - 1;

    always_comb begin
        synd = '0;
        for (int unsigned i = 0; i < HAM_N; i++) begin
            for (int unsigned k = 0; k < POS_W; k++) begin
                if (((i + 1) >> k) % 2 == 1)
                    synd[k] = synd[k] ^ codeword[i];
            end
        end
        synd[SYND_W-1] = ^codeword;
    end

    // Position 0 in the Hamming syndrome means the overall parity bit itself flipped.
    always_comb begin
        corrected = codeword;
        if (synd[SYND_W-1]) begin
            if (synd[POS_W-1:0] == '0)
                corrected[CW_W-1] = ~codeword[CW_W-1];
            for (int unsigned i = 0; i < HAM_N; i++) begin
                if (synd[POS_W-1:0] == POS_W'(i + 1))
                    corrected[i] = ~codeword[i];
            end
        end
    end

endmodule

// File: rtl/secded_scrubber.sv
// Background scrub engine: walks every address, reads and checks each codeword,
// writes back single-bit corrections and logs uncorrectable errors.
module secded_scrubber
    import secded_scrubber_pkg::*;
#(
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned INTERVAL = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 clr_stats,
    secded_scrubber_if.master    mem,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     ce_count,
    output logic [CNT_W-1:0]     ue_count,
    output logic                 ue_flag,
    output logic [ADDR_W-1:0]    ue_addr
);

    localparam int unsigned       IVL_W     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IVL_W-1:0]  IVL_LAST  = IVL_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [IVL_W-1:0]  ivl_q;
    logic [CW_W-1:0]   cw_q;
    logic [SYND_W-1:0] synd;
    logic [CW_W-1:0]   cw_fix;
    synd_class_e       synd_cls;
    logic              last_addr;

    secded_scrubber_ecc u_error_correction (
        .codeword  (cw_q),
        .synd      (synd),
        .corrected (cw_fix)
    );

    assign synd_cls  = classify_synd(synd);
    assign last_addr = (addr_q == ADDR_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = WAIT;
            WAIT:    if (ivl_q == IVL_LAST) state_d = READ;
            READ:    if (mem.mem_ack) state_d = CHECK;
            CHECK:   state_d = (synd_cls == SINGLE) ? WRITE : NEXT;
            WRITE:   if (mem.mem_ack) state_d = NEXT;
            NEXT:    state_d = (last_addr && !cont) ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = '0;
        busy          = (state_q != IDLE);
        unique case (state_q)
            READ: begin
                mem.mem_req = 1'b1;
            end
            WRITE: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_wdata = cw_fix;
            end
            default: ;
        endcase
    end

    // Datapath: address walk, inter-read spacing, captured codeword, end-of-pass pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ivl_q  <= '0;
            cw_q   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state_q == WAIT && ivl_q != IVL_LAST)
                ivl_q <= ivl_q + IVL_W'(1);
            else
                ivl_q <= '0;
            if (state_q == READ && mem.mem_ack)
                cw_q <= mem.mem_rdata;
            if (state_q == NEXT) begin
                addr_q <= last_addr ? '0 : addr_q + ADDR_W'(1);
                done   <= last_addr;
            end
        end
    end

    // A clear in the same cycle as a CHECK event wins and the event is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_count <= '0;
            ue_count <= '0;
            ue_flag  <= 1'b0;
            ue_addr  <= '0;
        end else if (clr_stats) begin
            ce_count <= '0;
            ue_count <= '0;
            ue_flag  <= 1'b0;
            ue_addr  <= '0;
        end else if (state_q == CHECK) begin
            unique case (synd_cls)
                SINGLE: begin
                    if (ce_count != '1)
                        ce_count <= ce_count + CNT_W'(1);
                end
                DOUBLE: begin
                    if (ue_count != '1)
                        ue_count <= ue_count + CNT_W'(1);
                    if (!ue_flag) begin
                        ue_flag <= 1'b1;
                        ue_addr <= addr_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_secded_scrubber.sv
// Randomised scoreboard bench for secded_scrubber: a behavioural RAM responds to
// requests, and a pass-level model predicts transactions and statistics.
module tb_secded_scrubber;
    import secded_scrubber_pkg::*;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned INTERVAL = 2;
    localparam int          CNT_MAX  = 3;

    typedef struct {
        logic        we;
        int          addr;
        logic [38:0] data;
    } txn_t;

    logic clk, rst_n, start, cont, clr_stats;
    logic busy, done, ue_flag;
    logic [CNT_W-1:0]  ce_count, ue_count;
    logic [ADDR_W-1:0] ue_addr;

    secded_scrubber_if #(.ADDR_W(ADDR_W)) mif ();

    secded_scrubber #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .INTERVAL (INTERVAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cont      (cont),
        .clr_stats (clr_stats),
        .mem       (mif),
        .busy      (busy),
        .done      (done),
        .ce_count  (ce_count),
        .ue_count  (ue_count),
        .ue_flag   (ue_flag),
        .ue_addr   (ue_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_vec = 0;
    int          n_err = 0;
    logic [38:0] mem  [DEPTH];
    logic [38:0] orig [DEPTH];
    int          err_n[DEPTH];
    txn_t        obs_q[$];
    txn_t        exp_q[$];
    int          m_ce, m_ue, m_flag, m_uaddr;
    int          ack_delay, clr_at_addr, hold_bad, wcnt;
    bit          hold_writes, in_txn, clr_next;
    logic        h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [38:0] h_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Extended Hamming: data fills non-power-of-two positions 1..38, check bit at 2^k
    // covers positions with bit k set, bit 38 makes total parity even.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] cw;
        logic        par;
        int unsigned j;
        cw = '0;
        j  = 0;
        for (int unsigned p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[j];
                j++;
            end
        end
        for (int unsigned k = 0; k < 6; k++) begin
            par = 1'b0;
            for (int unsigned p = 1; p <= 38; p++)
                if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0)
                    par = par ^ cw[p-1];
            cw[(1 << k) - 1] = par;
        end
        cw[38] = ^cw[37:0];
        return cw;
    endfunction

    // One clock of the RAM model, sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        mif.mem_ack = 1'b0;
        clr_stats   = clr_next;
        clr_next    = 1'b0;
        if (!rst_n) begin
            in_txn = 1'b0;
            return;
        end
        if (mif.mem_req) begin
            if (!in_txn) begin
                in_txn  = 1'b1;
                wcnt    = 0;
                h_we    = mif.mem_we;
                h_addr  = mif.mem_addr;
                h_wdata = mif.mem_wdata;
            end
            if (mif.mem_we !== h_we || mif.mem_addr !== h_addr || (h_we && mif.mem_wdata !== h_wdata))
                hold_bad++;
            if (!(mif.mem_we && hold_writes) && wcnt >= ack_delay) begin
                mif.mem_ack = 1'b1;
                in_txn      = 1'b0;
                if (mif.mem_we) begin
                    mem[mif.mem_addr] = mif.mem_wdata;
                end else begin
                    mif.mem_rdata = mem[mif.mem_addr];
                    if (int'(mif.mem_addr) == clr_at_addr)
                        clr_next = 1'b1;
                end
                obs_q.push_back('{mif.mem_we, int'(mif.mem_addr), mif.mem_wdata});
            end else begin
                wcnt++;
            end
        end else begin
            in_txn = 1'b0;
        end
    endtask

    task automatic init_mem();
        for (int a = 0; a < DEPTH; a++) begin
            orig[a]  = encode($urandom);
            mem[a]   = orig[a];
            err_n[a] = 0;
        end
    endtask

    task automatic inject(input int a, input int b0, input int b1);
        logic [38:0] m;
        m     = '0;
        m[b0] = 1'b1;
        if (b1 >= 0)
            m[b1] = 1'b1;
        mem[a]   = orig[a] ^ m;
        err_n[a] = (b1 >= 0) ? 2 : 1;
    endtask

    task automatic inject_random();
        int r, b0;
        for (int a = 0; a < DEPTH; a++) begin
            r  = $urandom_range(0, 3);
            b0 = $urandom_range(0, 38);
            if (r == 2)
                inject(a, b0, -1);
            else if (r == 3)
                inject(a, b0, (b0 + 1 + $urandom_range(0, 37)) % 39);
        end
    endtask

    task automatic model_clear();
        m_ce = 0; m_ue = 0; m_flag = 0; m_uaddr = 0;
    endtask

    // Appends one pass worth of expected traffic and advances the stats model.
    task automatic expect_pass(input int clr_a);
        for (int a = 0; a < DEPTH; a++) begin
            exp_q.push_back('{1'b0, a, 39'd0});
            if (err_n[a] == 1)
                exp_q.push_back('{1'b1, a, orig[a]});
            if (a == clr_a) begin
                model_clear();
            end else if (err_n[a] == 1) begin
                if (m_ce < CNT_MAX) m_ce++;
            end else if (err_n[a] == 2) begin
                if (m_ue < CNT_MAX) m_ue++;
                if (m_flag == 0) begin
                    m_flag  = 1;
                    m_uaddr = a;
                end
            end
            if (err_n[a] == 1)
                err_n[a] = 0;
        end
    endtask

    task automatic check_stats();
        check("ce_count", 64'(ce_count), 64'(m_ce));
        check("ue_count", 64'(ue_count), 64'(m_ue));
        check("ue_flag",  64'(ue_flag),  64'(m_flag));
        check("ue_addr",  64'(ue_addr),  64'(m_uaddr));
    endtask

    task automatic clear_stats();
        clr_next = 1'b1;
        tick();
        tick();
        model_clear();
    endtask

    task automatic run_pass(input string name, input int clr_a, input bit poke_start, input int passes);
        int dones;
        obs_q.delete();
        exp_q.delete();
        hold_bad    = 0;
        clr_at_addr = clr_a;
        for (int p = 0; p < passes; p++)
            expect_pass(p == 0 ? clr_a : -1);
        cont  = (passes > 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 4000 && dones < passes; i++) begin
            if (poke_start && i == 5)
                start = 1'b1;
            tick();
            start = 1'b0;
            if (done) begin
                dones++;
                cont = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) dones++;
        end
        check({name, ":done_pulses"}, 64'(dones), 64'(passes));
        check({name, ":busy_after"}, 64'(busy), 64'd0);
        check({name, ":hold_stable"}, 64'(hold_bad), 64'd0);
        check({name, ":txn_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check({name, ":txn_we"}, 64'(obs_q[i].we), 64'(exp_q[i].we));
            check({name, ":txn_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            if (exp_q[i].we)
                check({name, ":txn_wdata"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
        check_stats();
        clr_at_addr = -1;
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; cont = 1'b0; clr_stats = 1'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        ack_delay = 0; clr_at_addr = -1; hold_bad = 0; wcnt = 0;
        hold_writes = 1'b0; in_txn = 1'b0; clr_next = 1'b0;
        model_clear();
        init_mem();
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_req",  64'(mif.mem_req), 64'd0);
        check_stats();
        rst_n = 1'b1;
        tick();

        run_pass("clean", -1, 1'b1, 1);

        init_mem();
        inject(3, 5, -1);
        run_pass("single", -1, 1'b0, 1);

        clear_stats();
        check("clr_ce", 64'(ce_count), 64'd0);
        init_mem();
        inject(6, 2, 9);
        inject(7, 0, 38);
        run_pass("double", -1, 1'b0, 1);
        check("double_untouched", 64'(mem[6]), 64'(orig[6] ^ 39'h204));

        ack_delay = 5;
        init_mem();
        inject_random();
        run_pass("slow_ack", -1, 1'b0, 1);

        clear_stats();
        ack_delay = $urandom_range(0, 3);
        init_mem();
        for (int a = 0; a < 5; a++)
            inject(a, $urandom_range(0, 38), -1);
        run_pass("saturate", -1, 1'b0, 1);

        init_mem();
        inject(0, 7, -1);
        inject(2, 11, -1);
        inject(4, 1, 30);
        inject(5, 38, -1);
        run_pass("clr_at_check", 2, 1'b0, 1);

        for (int r = 0; r < 4; r++) begin
            ack_delay = $urandom_range(0, 5);
            init_mem();
            inject_random();
            run_pass("random", (r == 2) ? int'($urandom_range(0, DEPTH - 1)) : -1, 1'b1, 1);
        end

        ack_delay = 1;
        init_mem();
        inject_random();
        run_pass("cont", -1, 1'b0, 2);

        // Hold a write unacknowledged, then pull reset in the middle of it.
        ack_delay   = 0;
        hold_writes = 1'b1;
        init_mem();
        inject(1, 4, -1);
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < 500 && seen == 0; i++) begin
            tick();
            if (mif.mem_req && mif.mem_we) seen = 1;
        end
        check("rstw_write_seen", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        model_clear();
        check("rstw_req",  64'(mif.mem_req), 64'd0);
        check("rstw_we",   64'(mif.mem_we), 64'd0);
        check("rstw_busy", 64'(busy), 64'd0);
        check("rstw_done", 64'(done), 64'd0);
        check_stats();
        tick();
        tick();
        rst_n       = 1'b1;
        hold_writes = 1'b0;
        cont        = 1'b0;
        repeat (5) tick();
        check("rstw_idle_busy", 64'(busy), 64'd0);
        check("rstw_idle_req",  64'(mif.mem_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
